// File: rtl/minibyte_io_timer.sv
// minibyte_io_timer: memory-mapped GPIO latch and prescaled 8-bit down-counting
// timer for the Minibyte CPU bus. It decodes a 4-byte window at BASE_ADDR:
//   offset 0 GPIO, 1 CNT, 2 RELOAD, 3 CTRL {OVF, 4'b0, PS[1:0], EN}.
// The timer, prescaler and CTRL/OVF logic exist only when the macro
// MINIBYTE_IOT_TIMER_EN is defined. Without it, the block is a GPIO latch only.
module minibyte_io_timer #(
    parameter logic [6:0] BASE_ADDR = 7'h7C
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       ena_in,
    input  logic [6:0] addr_in,
    input  logic [7:0] data_in,
    input  logic       we_in,
    output logic [7:0] data_out,
    output logic       sel_out,
    output logic [7:0] gpio_out,
    output logic       tick_out
);

    localparam logic [1:0] OFS_GPIO   = 2'd0;
    localparam logic [1:0] OFS_CNT    = 2'd1;
    localparam logic [1:0] OFS_RELOAD = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    logic [7:0] gpio_q;
    logic [7:0] rd_data;
    logic [1:0] offset;
    logic       wr_en;

    assign sel_out  = (addr_in[6:2] == BASE_ADDR[6:2]);
    assign offset   = addr_in[1:0];
    assign wr_en    = sel_out & we_in & ena_in;
    assign gpio_out = gpio_q;
    assign data_out = rd_data;

    // GPIO output latch
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gpio_q <= 8'h00;
        end else if (wr_en && (offset == OFS_GPIO)) begin
            gpio_q <= data_in;
        end
    end

`ifdef MINIBYTE_IOT_TIMER_EN
    logic [7:0] cnt_q;
    logic [7:0] reload_q;
    logic       en_q;
    logic [1:0] ps_q;
    logic       ovf_q;
    logic [5:0] presc_q;
    logic       tick_q;
    logic [5:0] presc_term;
    logic       run;
    logic       presc_tc;
    logic       underflow;

    assign run       = en_q & ena_in;
    assign presc_tc  = run & (presc_q == presc_term);
    assign underflow = presc_tc & (cnt_q == 8'h00);
    assign tick_out  = tick_q;

    // Prescaler terminal value for the selected divide ratio (/1, /4, /16, /64)
    always_comb begin
        presc_term = 6'd0;
        case (ps_q)
            2'd0:    presc_term = 6'd0;
            2'd1:    presc_term = 6'd3;
            2'd2:    presc_term = 6'd15;
            default: presc_term = 6'd63;
        endcase
    end

    // Prescaler: restarts on any CTRL write so a new ratio starts a full period
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            presc_q <= 6'd0;
        end else if (wr_en && (offset == OFS_CTRL)) begin
            presc_q <= 6'd0;
        end else if (run) begin
            presc_q <= presc_tc ? 6'd0 : presc_q + 6'd1;
        end
    end

    // Count register: a bus write wins over decrement/reload in the same cycle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= 8'h00;
        end else if (wr_en && (offset == OFS_CNT)) begin
            cnt_q <= data_in;
        end else if (presc_tc) begin
            cnt_q <= underflow ? reload_q : cnt_q - 8'd1;
        end
    end

    // Reload register; an underflow in the same cycle still sees the old value
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            reload_q <= 8'h00;
        end else if (wr_en && (offset == OFS_RELOAD)) begin
            reload_q <= data_in;
        end
    end

    // CTRL enable and prescale select
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            en_q <= 1'b0;
            ps_q <= 2'd0;
        end else if (wr_en && (offset == OFS_CTRL)) begin
            en_q <= data_in[0];
            ps_q <= data_in[2:1];
        end
    end

    // Sticky overflow: setting on underflow wins over write-1-to-clear
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ovf_q <= 1'b0;
        end else if (underflow) begin
            ovf_q <= 1'b1;
        end else if (wr_en && (offset == OFS_CTRL) && data_in[7]) begin
            ovf_q <= 1'b0;
        end
    end

    // Registered underflow pulse, aligned with OVF first reading 1
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= underflow;
        end
    end

    // Read mux: combinational, side-effect free, zero when not selected
    always_comb begin
        rd_data = 8'h00;
        if (sel_out) begin
            case (offset)
                OFS_GPIO:   rd_data = gpio_q;
                OFS_CNT:    rd_data = cnt_q;
                OFS_RELOAD: rd_data = reload_q;
                default:    rd_data = {ovf_q, 4'b0000, ps_q, en_q};
            endcase
        end
    end
`else
    assign tick_out = 1'b0;

    // Read mux: only GPIO exists, all other offsets read zero
    always_comb begin
        rd_data = 8'h00;
        if (sel_out && (offset == OFS_GPIO)) begin
            rd_data = gpio_q;
        end
    end
`endif

endmodule

// File: tb/tb_minibyte_io_timer.sv
`timescale 1ns/1ps
module tb_minibyte_io_timer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       ena_in;
    logic [6:0] addr_in;
    logic [7:0] data_in;
    logic       we_in;
    logic [7:0] data_out;
    logic       sel_out;
    logic [7:0] gpio_out;
    logic       tick_out;

    int total = 0;
    int bad   = 0;

    minibyte_io_timer #(.BASE_ADDR(7'h7C)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .ena_in   (ena_in),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .we_in    (we_in),
        .data_out (data_out),
        .sel_out  (sel_out),
        .gpio_out (gpio_out),
        .tick_out (tick_out)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural reference: register contents plus a prescaler phase counted in cycles
    logic [7:0] m_gpio;
    logic [7:0] m_cnt;
    logic [7:0] m_rel;
    bit         m_en;
    bit         m_ovf;
    bit         m_tick;
    int         m_ps;
    int         m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_window(input logic [6:0] a);
        return a[6:2] == 5'b11111;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        logic [7:0] r;
        r = 8'h00;
        if (in_window(a)) begin
            case (a[1:0])
                2'd0: r = m_gpio;
`ifdef MINIBYTE_IOT_TIMER_EN
                2'd1: r = m_cnt;
                2'd2: r = m_rel;
                2'd3: r = {m_ovf, 4'b0000, 2'(m_ps), m_en};
`endif
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_gpio = 8'h00; m_cnt = 8'h00; m_rel = 8'h00;
        m_en = 0; m_ovf = 0; m_tick = 0; m_ps = 0; m_phase = 0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic model_edge();
        bit         wr;
        logic [1:0] off;
`ifdef MINIBYTE_IOT_TIMER_EN
        bit         running;
        bit         pt;
        bit         und;
        int         div;
        logic [7:0] nc;
`endif
        wr  = in_window(addr_in) && we_in && ena_in;
        off = addr_in[1:0];
        if (wr && off == 2'd0) m_gpio = data_in;
`ifdef MINIBYTE_IOT_TIMER_EN
        running = m_en && ena_in;
        div     = 1 << (2 * m_ps);
        pt      = running && (m_phase == div - 1);
        und     = pt && (m_cnt == 8'h00);
        nc      = m_cnt;
        if (pt) nc = und ? m_rel : m_cnt - 8'd1;
        if (wr && off == 2'd1) nc = data_in;
        if (wr && off == 2'd3) m_phase = 0;
        else if (running) m_phase = (m_phase + 1) % div;
        if (und) m_ovf = 1;
        else if (wr && off == 2'd3 && data_in[7]) m_ovf = 0;
        if (wr && off == 2'd3) begin
            m_en = data_in[0];
            m_ps = int'(data_in[2:1]);
        end
        if (wr && off == 2'd2) m_rel = data_in;
        m_cnt  = nc;
        m_tick = und;
`endif
    endtask

    task automatic drive(input logic [6:0] a, input logic [7:0] d, input logic we, input logic en);
        addr_in = a; data_in = d; we_in = we; ena_in = en;
        #1;
        check("sel_comb", sel_out, in_window(a));
        check("rd_comb", data_out, model_read(a));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_in);
        #1;
        check("gpio", gpio_out, m_gpio);
        check("tick", tick_out, m_tick);
        check("rd", data_out, model_read(addr_in));
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        drive(a, d, 1'b1, 1'b1);
        cycle();
    endtask

    task automatic idle();
        drive(7'h7D, 8'h00, 1'b0, 1'b1);
        cycle();
    endtask

`ifdef MINIBYTE_IOT_TIMER_EN
    function automatic bit model_und_next();
        int div;
        div = 1 << (2 * m_ps);
        return m_en && (m_phase == div - 1) && (m_cnt == 8'h00);
    endfunction

    // Count cycles until tick_out, optionally holding ena_in low for 10 cycles
    task automatic wait_tick(input int off_at, output int n);
        bit en;
        for (n = 1; n <= 200; n++) begin
            en = !(n >= off_at && n < off_at + 10);
            drive(7'h7D, 8'h00, 1'b0, en);
            cycle();
            if (tick_out === 1'b1) return;
        end
        check("tick_timeout", 0, 1);
    endtask

    task automatic wait_und();
        for (int i = 0; i < 300; i++) begin
            if (model_und_next()) return;
            idle();
        end
        check("und_timeout", 0, 1);
    endtask
`endif

    typedef struct {
        logic [6:0] a;
        logic [7:0] d;
        logic       we;
        logic       exp_sel;
        logic [7:0] exp_gpio;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int q[$];
        int n;

        vecs[0] = '{7'h7C, 8'hA5, 1'b1, 1'b1, 8'hA5, 8'hA5};
        vecs[1] = '{7'h7B, 8'h11, 1'b1, 1'b0, 8'hA5, 8'h00};
        vecs[2] = '{7'h3C, 8'h22, 1'b1, 1'b0, 8'hA5, 8'h00};
        vecs[3] = '{7'h7C, 8'h5A, 1'b0, 1'b1, 8'hA5, 8'hA5};
        vecs[4] = '{7'h7C, 8'h3C, 1'b1, 1'b1, 8'h3C, 8'h3C};
        vecs[5] = '{7'h00, 8'hFF, 1'b1, 1'b0, 8'h3C, 8'h00};
        vecs[6] = '{7'h7C, 8'h81, 1'b1, 1'b1, 8'h81, 8'h81};

        rst_in = 1'b0; ena_in = 1'b1; addr_in = 7'h7C; data_in = 8'h00; we_in = 1'b0;
        model_reset();
        #1;
        check("reset_gpio", gpio_out, 8'h00);
        check("reset_tick", tick_out, 1'b0);
        check("reset_rd", data_out, 8'h00);
        @(negedge clk_in);
        rst_in = 1'b1;
        drive(7'h7C, 8'h00, 1'b0, 1'b1);
        cycle();

        // Decode and GPIO vectors
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].d, vecs[i].we, 1'b1);
            check("vec_sel", sel_out, vecs[i].exp_sel);
            cycle();
            check("vec_gpio", gpio_out, vecs[i].exp_gpio);
            check("vec_rd", data_out, vecs[i].exp_rd);
        end

        // Write with design disabled is ignored
        drive(7'h7C, 8'h77, 1'b1, 1'b0);
        cycle();
        check("ena_low_gpio", gpio_out, 8'h81);

`ifndef MINIBYTE_IOT_TIMER_EN
        for (int i = 1; i < 4; i++) begin
            wr(7'(7'h7C + i), 8'hFF);
            drive(7'(7'h7C + i), 8'h00, 1'b0, 1'b1);
            check("notimer_rd", data_out, 8'h00);
        end
        for (int i = 0; i < 20; i++) begin
            idle();
            check("notimer_tick", tick_out, 1'b0);
        end
        wr(7'h7C, 8'hC3);
        check("notimer_gpio", gpio_out, 8'hC3);
`else
        // /1 timer, RELOAD = CNT = 3: first tick 4 cycles after EN, then every 4
        wr(7'h7E, 8'h03);
        wr(7'h7D, 8'h03);
        wr(7'h7F, 8'h01);
        for (int i = 1; i <= 20 && q.size() < 3; i++) begin
            idle();
            if (tick_out === 1'b1) q.push_back(i);
        end
        check("div1_ticks", q.size(), 3);
        if (q.size() == 3) begin
            check("div1_first", q[0], 4);
            check("div1_period_a", q[1] - q[0], 4);
            check("div1_period_b", q[2] - q[1], 4);
        end
        drive(7'h7F, 8'h00, 1'b0, 1'b1);
        check("ovf_set", data_out, 8'h81);
        wr(7'h7F, 8'h80);
        drive(7'h7F, 8'h00, 1'b0, 1'b1);
        check("ovf_clear", data_out, 8'h00);
        wr(7'h7D, 8'h42);
        for (int i = 0; i < 5; i++) idle();
        check("en0_cnt_hold", data_out, 8'h42);

        // /16 with RELOAD = 0, then a period stretched by ena_in low
        wr(7'h7E, 8'h00);
        wr(7'h7D, 8'h00);
        wr(7'h7F, 8'h05);
        wait_tick(-100, n);
        check("div16_period", n, 16);
        wait_tick(5, n);
        check("div16_stretch", n, 26);

        // Collisions at /1 with RELOAD = 5
        wr(7'h7E, 8'h05);
        wr(7'h7F, 8'h01);
        wait_und();
        wr(7'h7D, 8'h20);
        check("coll_cnt", data_out, 8'h20);
        check("coll_cnt_tick", tick_out, 1'b1);
        drive(7'h7F, 8'h00, 1'b0, 1'b1);
        check("coll_cnt_ovf", data_out[7], 1'b1);
        wait_und();
        wr(7'h7F, 8'h81);
        check("coll_ovf", data_out, 8'h81);
        wait_und();
        wr(7'h7E, 8'h09);
        drive(7'h7D, 8'h00, 1'b0, 1'b1);
        check("coll_reload", data_out, 8'h05);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 9) < 8) ? 7'(7'h7C + $urandom_range(0, 3)) : 7'($urandom);
            drive(a, 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) != 0));
            cycle();
        end

        // Asynchronous reset mid-count with GPIO = 5A
        wr(7'h7C, 8'h5A);
`ifdef MINIBYTE_IOT_TIMER_EN
        wr(7'h7E, 8'h00);
        wr(7'h7F, 8'h01);
`endif
        idle();
        idle();
        #1;
        rst_in = 1'b0;
        model_reset();
        #0.5;
        check("arst_gpio", gpio_out, 8'h00);
        check("arst_tick", tick_out, 1'b0);
        for (int i = 0; i < 4; i++) begin
            addr_in = 7'(7'h7C + i);
            we_in = 1'b0;
            #0.5;
            check("arst_rd", data_out, 8'h00);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        drive(7'h7C, 8'h00, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 4; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
